tel_frame_tx: RTL and testbench
===============================

# tel_frame_tx

Serial transmitter for the telephone display. Monitors the 64-bit ASCII `statusMsg` and `sentMsg` buses produced by the call-control FSM and sends a fixed 20-byte text frame over an 8N1 UART line whenever either bus changes. It is the host-side end of the display interface: the call FSM writes the characters and this block carries them off-chip to a terminal.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `statusMsg`  in  64  8 ASCII chars; `[63:56]` is the leftmost char.
- `sentMsg`  in  64  8 ASCII chars; same ordering.
- `tx`  out  1  UART serial line, idles high.
- `busy`  out  1  high while a frame is on the line.
- `frame_done`  out  1  one-cycle pulse after the last stop bit of a frame.

## Operation
- Frame layout, in byte order: STX 0x02, `statusMsg[63:56]` … `statusMsg[7:0]`, separator 0x7C '|', `sentMsg[63:56]` … `sentMsg[7:0]`, CR 0x0D, LF 0x0A. Total 20 bytes.
- Each byte is sent 8N1: start bit 0, data LSB first, stop bit 1. The frame is 200 bits with no idle gap between bytes.
- Shadow register (128 b) holds the last transmitted pair and resets to all zeros, so the first frame after reset is always sent.
- Frame FSM states:
  - IDLE: if `{statusMsg,sentMsg} != shadow`, latch the inputs into both snapshot and shadow, set byte index to 0, and go to SEND.
  - SEND: drive the bytes of the snapshot in order. After byte 19's stop bit, go to DONE.
  - DONE: pulse `frame_done` and return to IDLE.
- Inputs are sampled only when entering SEND. Changes during a frame do not alter the frame in flight.
- In IDLE the compare runs again immediately. If the inputs now differ from the shadow, the next frame starts back to back. Intermediate values that appear and revert during a frame are never transmitted.
- Bit FSM (sub-module):
  - IDLE → START → DATA ×8 → STOP → IDLE.
  - Each state lasts exactly `CLKS_PER_BIT` cycles, counted by a baud counter of width `$clog2(CLKS_PER_BIT)` that wraps at `CLKS_PER_BIT-1`.
- Bytes are passed to the sub-module with a valid/ready handshake. A new byte is accepted in the same cycle the previous stop bit ends, so there is no gap.

## Timing
- Reset values: `tx`=1, `busy`=0, `frame_done`=0. FSMs are in IDLE, counters are 0, shadow and snapshot are 0.
- Reset asserted mid-frame: `tx` returns high immediately and the frame is abandoned. Because the shadow is cleared, a full frame is sent after release.
- Latency: if the inputs differ from the shadow in cycle N (FSM in IDLE), `busy` and `tx`=0 (the start bit) are registered at the edge ending cycle N. The start bit is visible in cycle N+1.
- Bit k of the frame (k = 0..199) occupies cycles N+1+k·CLKS_PER_BIT through N+(k+1)·CLKS_PER_BIT.
- `frame_done` is high in cycle N+1+200·CLKS_PER_BIT. In that same cycle `busy` falls.
- Earliest start of the next frame: the cycle after `frame_done`. Minimum inter-frame idle time is 1 cycle with `tx`=1.
- Inputs that change in the same cycle the FSM leaves IDLE: the value present at that edge is the one snapshotted.

## Structure
- Package `tel_pkg` holds:
  - byte constants `TEL_STX`, `TEL_SEP`, `TEL_CR`, `TEL_LF`;
  - `TEL_FRAME_BYTES`=20 and `TEL_MSG_CHARS`=8;
  - the frame-state enum.
- Sub-module `tel_uart_byte_tx` has ports `clk`, `rst_n`, `data[7:0]`, `valid`, `ready`, `tx`, and parameter `CLKS_PER_BIT`. It contains the bit FSM and the baud counter.
- The top level contains:
  - the shadow and snapshot registers;
  - the comparator;
  - a 5-bit byte index;
  - a byte mux selecting STX, snapshot chars, separator, CR or LF from the index.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, so one frame is 800 cycles.
- Reset release with `statusMsg`="IDLE    " and `sentMsg`=8 spaces → one frame is sent. A UART monitor decodes 02 'I' 'D' 'L' 'E' 20 20 20 20 7C 20×8 0D 0A; `frame_done` pulses once at cycle 801 after start.
- Inputs held constant after that frame → `tx` stays 1 and `busy` stays 0 for 2000 cycles.
- `statusMsg` changes to "RINGING " at cycle 100 of a frame → the current frame still carries "IDLE    ". A second frame carrying "RINGING " starts the cycle after `frame_done`.
- During one frame, `sentMsg` goes "A" → "AB" → back to "A", with "A" being the shadow value → no second frame is sent.
- `rst_n` pulsed low at bit 57 → `tx`=1 asynchronously. After release a full frame with the current inputs is sent.
- `CLKS_PER_BIT`=2 boundary → every bit is exactly 2 cycles wide and the frame is 400 cycles; decode is correct.

Source files
------------

// File: rtl/tel_pkg.sv
// Shared constants, state enums and frame byte selection for the telephone display UART link.
package tel_pkg;

    localparam logic [7:0] TEL_STX = 8'h02;
    localparam logic [7:0] TEL_SEP = 8'h7C;
    localparam logic [7:0] TEL_CR  = 8'h0D;
    localparam logic [7:0] TEL_LF  = 8'h0A;

    localparam int unsigned TEL_FRAME_BYTES = 20;
    localparam int unsigned TEL_MSG_CHARS   = 8;
    localparam int unsigned TEL_IDX_W       = 5;

    typedef enum logic [1:0] {
        FRM_IDLE,
        FRM_SEND,
        FRM_DONE
    } frm_state_e;

    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP
    } bit_state_e;

    typedef struct packed {
        logic [8*TEL_MSG_CHARS-1:0] status;
        logic [8*TEL_MSG_CHARS-1:0] sent;
    } tel_msg_t;

    // Byte idx of the frame: STX, 8 status chars, '|', 8 sent chars, CR, LF
    function automatic logic [7:0] tel_frame_byte(input logic [TEL_IDX_W-1:0] idx,
                                                  input tel_msg_t             snap);
        logic [2*TEL_MSG_CHARS-1:0][7:0] chars;
        logic [7:0]                      byte_v;
        chars  = snap;
        byte_v = TEL_LF;
        if (idx == 5'd0)        byte_v = TEL_STX;
        else if (idx <= 5'd8)   byte_v = chars[4'(5'd16 - idx)];
        else if (idx == 5'd9)   byte_v = TEL_SEP;
        else if (idx <= 5'd17)  byte_v = chars[4'(5'd17 - idx)];
        else if (idx == 5'd18)  byte_v = TEL_CR;
        return byte_v;
    endfunction

endpackage

// File: rtl/tel_frame_tx_if.sv
// Display message buses and UART line status between the call-control side and tel_frame_tx.
interface tel_frame_tx_if;
    logic [63:0] statusMsg;
    logic [63:0] sentMsg;
    logic        tx;
    logic        busy;
    logic        frame_done;

    modport master (output statusMsg, sentMsg, input tx, busy, frame_done);
    modport slave  (input statusMsg, sentMsg, output tx, busy, frame_done);
endinterface

// File: rtl/tel_uart_byte_tx.sv
// 8N1 byte serializer; a new byte is accepted in the last cycle of the previous stop bit.
module tel_uart_byte_tx
    import tel_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    bit_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shreg_q;
    logic             tx_q, tx_d;
    logic             bit_end, load;

    assign bit_end = (cnt_q == CNT_LAST);
    assign ready   = (state_q == BIT_IDLE) || ((state_q == BIT_STOP) && bit_end);
    assign load    = valid && ready;
    assign tx      = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BIT_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BIT_IDLE:  if (load) state_d = BIT_START;
            BIT_START: if (bit_end) state_d = BIT_DATA;
            BIT_DATA:  if (bit_end && (bit_q == 3'd7)) state_d = BIT_STOP;
            BIT_STOP:  if (bit_end) state_d = load ? BIT_START : BIT_IDLE;
            default:   state_d = BIT_IDLE;
        endcase
    end

    // Line level for the next bit, decided at each bit boundary
    always_comb begin
        tx_d = tx_q;
        if (load) begin
            tx_d = 1'b0;
        end else if (bit_end) begin
            unique case (state_q)
                BIT_START: tx_d = shreg_q[0];
                BIT_DATA:  tx_d = (bit_q == 3'd7) ? 1'b1 : shreg_q[1];
                BIT_STOP:  tx_d = 1'b1;
                default:   tx_d = tx_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            if (load) begin
                shreg_q <= data;
                cnt_q   <= '0;
                bit_q   <= '0;
            end else if (state_q != BIT_IDLE) begin
                cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
                if ((state_q == BIT_DATA) && bit_end) begin
                    bit_q   <= bit_q + 1'b1;
                    shreg_q <= {1'b0, shreg_q[7:1]};
                end
            end
            tx_q <= tx_d;
        end
    end

endmodule

// File: rtl/tel_frame_tx.sv
// Sends a 20-byte STX/status/'|'/sent/CR/LF frame over UART whenever the message pair changes.
module tel_frame_tx
    import tel_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic          clk,
    input  logic          rst_n,
    tel_frame_tx_if.slave bus
);

    localparam logic [TEL_IDX_W-1:0] IDX_END = TEL_IDX_W'(TEL_FRAME_BYTES);

    frm_state_e           state_q, state_d;
    tel_msg_t             in_msg, shadow_q, snap_q;
    logic [TEL_IDX_W-1:0] idx_q;
    logic                 diff_c, launch_c, byte_valid_c, byte_ready;
    logic [7:0]           byte_data_c;
    logic                 busy_q, frame_done_q, uart_tx;

    assign in_msg = {bus.statusMsg, bus.sentMsg};
    assign diff_c = (in_msg != shadow_q);

    assign bus.tx         = uart_tx;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FRM_IDLE;
        else        state_q <= state_d;
    end

    // DONE also launches so back-to-back frames have a single idle-high cycle between them
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FRM_IDLE: if (diff_c && byte_ready) state_d = FRM_SEND;
            FRM_SEND: if ((idx_q == IDX_END) && byte_ready) state_d = FRM_DONE;
            FRM_DONE: state_d = (diff_c && byte_ready) ? FRM_SEND : FRM_IDLE;
            default:  state_d = FRM_IDLE;
        endcase
    end

    // idx_q is 0 outside SEND, so the launching byte is STX before the snapshot is loaded
    always_comb begin
        launch_c     = 1'b0;
        byte_valid_c = 1'b0;
        unique case (state_q)
            FRM_IDLE, FRM_DONE: begin
                launch_c     = diff_c && byte_ready;
                byte_valid_c = diff_c;
            end
            FRM_SEND: byte_valid_c = (idx_q != IDX_END);
            default:  byte_valid_c = 1'b0;
        endcase
        byte_data_c = tel_frame_byte(idx_q, snap_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q     <= '0;
            snap_q       <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (launch_c) begin
                shadow_q <= in_msg;
                snap_q   <= in_msg;
                idx_q    <= TEL_IDX_W'(1);
            end else if (byte_valid_c && byte_ready) begin
                idx_q <= idx_q + 1'b1;
            end else if (state_d == FRM_DONE) begin
                idx_q <= '0;
            end
            busy_q       <= (state_d == FRM_SEND);
            frame_done_q <= (state_q == FRM_SEND) && (state_d == FRM_DONE);
        end
    end

    tel_uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (byte_data_c),
        .valid (byte_valid_c),
        .ready (byte_ready),
        .tx    (uart_tx)
    );

endmodule

// File: tb/tb_tel_frame_tx.sv
// Bench for tel_frame_tx: decodes the UART line and compares against a byte-level frame model.
module tb_tel_frame_tx;

    localparam int CPB1 = 4;
    localparam int CPB2 = 2;

    typedef struct {
        bit              ok;
        int              start_c;
        int              done_c;
        int              bad_line;
        logic            end_done;
        logic            end_busy;
        logic            end_tx;
        logic [19:0][7:0] got;
    } cap_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst2_n = 1'b0;
    int   cyc      = 0;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    tel_frame_tx_if bus1();
    tel_frame_tx_if bus2();

    tel_frame_tx #(.CLKS_PER_BIT(CPB1)) dut1 (.clk(clk), .rst_n(rst_n),  .bus(bus1));
    tel_frame_tx #(.CLKS_PER_BIT(CPB2)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic tx_of(input int sel);
        return (sel == 1) ? bus1.tx : bus2.tx;
    endfunction
    function automatic logic busy_of(input int sel);
        return (sel == 1) ? bus1.busy : bus2.busy;
    endfunction
    function automatic logic done_of(input int sel);
        return (sel == 1) ? bus1.frame_done : bus2.frame_done;
    endfunction

    task automatic set_msg(input int sel, input logic [63:0] st, input logic [63:0] se);
        if (sel == 1) begin bus1.statusMsg = st; bus1.sentMsg = se; end
        else          begin bus2.statusMsg = st; bus2.sentMsg = se; end
    endtask

    // Reference frame: element i is the i-th byte on the line
    function automatic logic [19:0][7:0] model_frame(input logic [63:0] st, input logic [63:0] se);
        logic [19:0][7:0] f;
        f[0] = 8'h02;
        for (int i = 0; i < 8; i++) f[1 + i] = st[63 - 8*i -: 8];
        f[9] = 8'h7C;
        for (int i = 0; i < 8; i++) f[10 + i] = se[63 - 8*i -: 8];
        f[18] = 8'h0D;
        f[19] = 8'h0A;
        return f;
    endfunction

    function automatic logic [63:0] rand_msg();
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = 8'($urandom_range(32, 126));
        return m;
    endfunction

    // Waits for a start bit, then samples all 200 bit periods cycle by cycle against exp_f
    task automatic capture(input int sel, input logic [19:0][7:0] exp_f,
                           input int c1_at, input logic [63:0] c1_st, input logic [63:0] c1_se,
                           input int c2_at, input logic [63:0] c2_st, input logic [63:0] c2_se,
                           output cap_t r);
        int   cpb, waited, s, by, pos;
        logic exp_b, b;
        cpb = (sel == 1) ? CPB1 : CPB2;
        r.ok = 1'b0; r.start_c = 0; r.done_c = 0; r.bad_line = 0;
        r.end_done = 1'b0; r.end_busy = 1'b1; r.end_tx = 1'b0; r.got = '0;
        waited = 0;
        @(negedge clk);
        while (tx_of(sel) !== 1'b0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (tx_of(sel) !== 1'b0) return;
        r.ok = 1'b1;
        r.start_c = cyc;
        for (int k = 0; k < 200; k++) begin
            by  = k / 10;
            pos = k % 10;
            exp_b = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : exp_f[by][pos-1];
            for (int j = 0; j < cpb; j++) begin
                if (k != 0 || j != 0) @(negedge clk);
                s = k * cpb + j;
                if (s == c1_at) set_msg(sel, c1_st, c1_se);
                if (s == c2_at) set_msg(sel, c2_st, c2_se);
                b = tx_of(sel);
                if (b !== exp_b) r.bad_line++;
                if (busy_of(sel) !== 1'b1 || done_of(sel) !== 1'b0) r.bad_line++;
                if (j == cpb / 2 && pos >= 1 && pos <= 8) r.got[by][pos-1] = b;
            end
        end
        @(negedge clk);
        r.done_c   = cyc;
        r.end_done = done_of(sel);
        r.end_busy = busy_of(sel);
        r.end_tx   = tx_of(sel);
    endtask

    task automatic test_reset();
        cap_t r;
        logic [19:0][7:0] e;
        int rel;
        rst_n = 1'b0;
        set_msg(1, "IDLE    ", "        ");
        repeat (5) @(negedge clk);
        chk_cnt++; if (bus1.tx !== 1'b1) $display("FAIL reset_tx: got %b required 1", bus1.tx); else pass_cnt++;
        chk_cnt++; if (bus1.busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", bus1.busy); else pass_cnt++;
        chk_cnt++; if (bus1.frame_done !== 1'b0) $display("FAIL reset_done: got %b required 0", bus1.frame_done); else pass_cnt++;
        rst_n = 1'b1;
        rel = cyc;
        e = model_frame("IDLE    ", "        ");
        capture(1, e, -1, '0, '0, -1, '0, '0, r);
        chk_cnt++; if (!r.ok || r.start_c != rel + 1) $display("FAIL first_latency: got start ok=%0d offset %0d required offset 1", r.ok, r.start_c - rel); else pass_cnt++;
        chk_cnt++; if (r.got !== e) $display("FAIL first_bytes: got %h required %h", r.got, e); else pass_cnt++;
        chk_cnt++; if (r.bad_line != 0) $display("FAIL first_line: got %0d bad samples required 0", r.bad_line); else pass_cnt++;
        chk_cnt++; if (r.done_c != r.start_c + 200*CPB1 || r.end_done !== 1'b1 || r.end_busy !== 1'b0 || r.end_tx !== 1'b1)
            $display("FAIL first_done: got offset %0d done=%b busy=%b tx=%b required offset %0d done=1 busy=0 tx=1",
                     r.done_c - r.start_c, r.end_done, r.end_busy, r.end_tx, 200*CPB1);
        else pass_cnt++;
    endtask

    task automatic test_idle_hold();
        int bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (bus1.tx !== 1'b1 || bus1.busy !== 1'b0 || bus1.frame_done !== 1'b0) bad++;
        end
        chk_cnt++; if (bad != 0) $display("FAIL idle_hold: got %0d active cycles required 0", bad); else pass_cnt++;
    endtask

    task automatic test_change_mid_frame();
        cap_t r1, r2;
        logic [19:0][7:0] e1, e2;
        set_msg(1, "IDLE    ", "DIAL 555");
        e1 = model_frame("IDLE    ", "DIAL 555");
        e2 = model_frame("RINGING ", "DIAL 555");
        capture(1, e1, 100, "RINGING ", "DIAL 555", -1, '0, '0, r1);
        chk_cnt++; if (r1.got !== e1) $display("FAIL inflight_bytes: got %h required %h", r1.got, e1); else pass_cnt++;
        chk_cnt++; if (r1.bad_line != 0) $display("FAIL inflight_line: got %0d bad samples required 0", r1.bad_line); else pass_cnt++;
        chk_cnt++; if (r1.done_c != r1.start_c + 200*CPB1 || r1.end_done !== 1'b1 || r1.end_busy !== 1'b0)
            $display("FAIL inflight_done: got offset %0d done=%b busy=%b required offset %0d done=1 busy=0",
                     r1.done_c - r1.start_c, r1.end_done, r1.end_busy, 200*CPB1);
        else pass_cnt++;
        capture(1, e2, -1, '0, '0, -1, '0, '0, r2);
        chk_cnt++; if (!r2.ok || r2.start_c != r1.done_c + 1) $display("FAIL ringing_b2b: got start ok=%0d gap %0d required gap 1", r2.ok, r2.start_c - r1.done_c); else pass_cnt++;
        chk_cnt++; if (r2.got !== e2) $display("FAIL ringing_bytes: got %h required %h", r2.got, e2); else pass_cnt++;
        chk_cnt++; if (r2.bad_line != 0) $display("FAIL ringing_line: got %0d bad samples required 0", r2.bad_line); else pass_cnt++;
    endtask

    task automatic test_revert();
        cap_t r;
        logic [19:0][7:0] e;
        int bad = 0;
        set_msg(1, "RINGING ", "A       ");
        e = model_frame("RINGING ", "A       ");
        capture(1, e, 100, "RINGING ", "AB      ", 400, "RINGING ", "A       ", r);
        chk_cnt++; if (r.got !== e) $display("FAIL revert_bytes: got %h required %h", r.got, e); else pass_cnt++;
        chk_cnt++; if (r.bad_line != 0 || r.end_done !== 1'b1) $display("FAIL revert_line: got %0d bad samples done=%b required 0 and 1", r.bad_line, r.end_done); else pass_cnt++;
        repeat (1000) begin
            @(negedge clk);
            if (bus1.tx !== 1'b1 || bus1.busy !== 1'b0) bad++;
        end
        chk_cnt++; if (bad != 0) $display("FAIL revert_no_frame: got %0d active cycles required 0", bad); else pass_cnt++;
    endtask

    task automatic test_back_to_back_random();
        cap_t r1, r2;
        logic [63:0] a_st, a_se, b_st, b_se;
        logic [19:0][7:0] e1, e2;
        for (int it = 0; it < 3; it++) begin
            a_st = rand_msg(); a_se = rand_msg();
            b_st = rand_msg(); b_se = rand_msg();
            if (b_st == a_st) b_st = ~a_st;
            set_msg(1, a_st, a_se);
            e1 = model_frame(a_st, a_se);
            e2 = model_frame(b_st, b_se);
            capture(1, e1, int'($urandom_range(5, 790)), b_st, b_se, -1, '0, '0, r1);
            chk_cnt++; if (r1.got !== e1 || r1.bad_line != 0) $display("FAIL rand%0d_first: got %h bad=%0d required %h bad=0", it, r1.got, r1.bad_line, e1); else pass_cnt++;
            capture(1, e2, -1, '0, '0, -1, '0, '0, r2);
            chk_cnt++; if (!r2.ok || r2.start_c != r1.done_c + 1) $display("FAIL rand%0d_b2b: got start ok=%0d gap %0d required gap 1", it, r2.ok, r2.start_c - r1.done_c); else pass_cnt++;
            chk_cnt++; if (r2.got !== e2 || r2.bad_line != 0) $display("FAIL rand%0d_second: got %h bad=%0d required %h bad=0", it, r2.got, r2.bad_line, e2); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_frame();
        cap_t r;
        logic [19:0][7:0] e;
        int waited = 0;
        int rel;
        e = model_frame("CALL 123", "        ");
        set_msg(1, "CALL 123", "        ");
        @(negedge clk);
        while (bus1.tx !== 1'b0 && waited < 3000) begin @(negedge clk); waited++; end
        repeat (57*CPB1 + 1) @(negedge clk);
        chk_cnt++; if (bus1.tx !== e[5][6]) $display("FAIL bit57_level: got %b required %b", bus1.tx, e[5][6]); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (bus1.tx !== 1'b1 || bus1.busy !== 1'b0) $display("FAIL async_reset: got tx=%b busy=%b required tx=1 busy=0", bus1.tx, bus1.busy); else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        capture(1, e, -1, '0, '0, -1, '0, '0, r);
        chk_cnt++; if (!r.ok || r.start_c != rel + 1) $display("FAIL rerun_latency: got start ok=%0d offset %0d required offset 1", r.ok, r.start_c - rel); else pass_cnt++;
        chk_cnt++; if (r.got !== e || r.bad_line != 0) $display("FAIL rerun_frame: got %h bad=%0d required %h bad=0", r.got, r.bad_line, e); else pass_cnt++;
    endtask

    task automatic test_cpb2();
        cap_t r1, r2;
        logic [63:0] a_st, a_se, b_se;
        logic [19:0][7:0] e1, e2;
        int rel;
        a_st = rand_msg(); a_se = rand_msg(); b_se = rand_msg();
        if (b_se == a_se) b_se = ~a_se;
        set_msg(2, a_st, a_se);
        repeat (3) @(negedge clk);
        chk_cnt++; if (bus2.tx !== 1'b1 || bus2.busy !== 1'b0) $display("FAIL cpb2_reset: got tx=%b busy=%b required tx=1 busy=0", bus2.tx, bus2.busy); else pass_cnt++;
        rst2_n = 1'b1;
        rel = cyc;
        e1 = model_frame(a_st, a_se);
        e2 = model_frame(a_st, b_se);
        capture(2, e1, 150, a_st, b_se, -1, '0, '0, r1);
        chk_cnt++; if (!r1.ok || r1.start_c != rel + 1) $display("FAIL cpb2_latency: got start ok=%0d offset %0d required offset 1", r1.ok, r1.start_c - rel); else pass_cnt++;
        chk_cnt++; if (r1.got !== e1 || r1.bad_line != 0) $display("FAIL cpb2_first: got %h bad=%0d required %h bad=0", r1.got, r1.bad_line, e1); else pass_cnt++;
        chk_cnt++; if (r1.done_c != r1.start_c + 200*CPB2 || r1.end_done !== 1'b1 || r1.end_busy !== 1'b0)
            $display("FAIL cpb2_done: got offset %0d done=%b busy=%b required offset %0d done=1 busy=0",
                     r1.done_c - r1.start_c, r1.end_done, r1.end_busy, 200*CPB2);
        else pass_cnt++;
        capture(2, e2, -1, '0, '0, -1, '0, '0, r2);
        chk_cnt++; if (!r2.ok || r2.start_c != r1.done_c + 1) $display("FAIL cpb2_b2b: got start ok=%0d gap %0d required gap 1", r2.ok, r2.start_c - r1.done_c); else pass_cnt++;
        chk_cnt++; if (r2.got !== e2 || r2.bad_line != 0) $display("FAIL cpb2_second: got %h bad=%0d required %h bad=0", r2.got, r2.bad_line, e2); else pass_cnt++;
    endtask

    initial begin
        set_msg(1, '0, '0);
        set_msg(2, '0, '0);
        test_reset();
        test_idle_hold();
        test_change_mid_frame();
        test_revert();
        test_back_to_back_random();
        test_reset_mid_frame();
        test_cpb2();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
